// File: rtl/prog_clkdiv_pkg.sv
// Shared types and defaults for the programmable clock divider.
package prog_clkdiv_pkg;

    localparam int unsigned CNT_W_DEF = 8;

    // Per-channel lifecycle: stopped, toggling, or finishing a high phase before stopping.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } ch_state_t;

endpackage

// File: rtl/clk_div_channel.sv
// One divided-clock channel: half-period counter, pending divisor and glitch-free stop.
module clk_div_channel
    import prog_clkdiv_pkg::*;
#(
    parameter int unsigned CNT_W        = CNT_W_DEF,
    parameter int unsigned DEFAULT_HALF = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic             sync_align,
    input  logic             cfg_wr,
    input  logic [CNT_W-1:0] cfg_half,
    output logic             clk_out,
    output logic             active
);

    ch_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic             lvl;
    logic [CNT_W-1:0] cur_h;
    logic [CNT_W-1:0] pend_h;
    logic             pend_v;

    logic [CNT_W-1:0] eff_h;
    logic [CNT_W-1:0] eff_h_m1;
    logic [CNT_W-1:0] cur_h_m1;
    logic [CNT_W-1:0] cnt_m1;

    // Half-period that takes effect at the next apply point.
    assign eff_h    = pend_v ? pend_h : cur_h;
    assign eff_h_m1 = eff_h - CNT_W'(1);
    assign cur_h_m1 = cur_h - CNT_W'(1);
    assign cnt_m1   = cnt - CNT_W'(1);

    assign active = (state != IDLE);

    // Channel state machine, counter, pending divisor and output flop.
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            lvl     <= 1'b0;
            cur_h   <= CNT_W'(DEFAULT_HALF);
            pend_h  <= '0;
            pend_v  <= 1'b0;
            clk_out <= 1'b0;
        end else begin
            clk_out <= lvl;
            case (state)
                IDLE: begin
                    cur_h  <= eff_h;
                    pend_v <= 1'b0;
                    lvl    <= 1'b0;
                    if (en && (eff_h != '0)) begin
                        state <= RUN;
                        lvl   <= 1'b1;
                        cnt   <= eff_h_m1;
                    end
                end
                RUN: begin
                    if (!en) begin
                        // Low phase may stop at once; high phase must complete first.
                        if (!lvl) begin
                            state <= IDLE;
                        end else if (cnt == '0) begin
                            lvl   <= 1'b0;
                            state <= IDLE;
                        end else begin
                            cnt   <= cnt_m1;
                            state <= STOPPING;
                        end
                    end else if (sync_align || ((cnt == '0) && !lvl)) begin
                        // Period restart: alignment request or natural boundary.
                        cur_h  <= eff_h;
                        pend_v <= 1'b0;
                        if (eff_h == '0) begin
                            state <= IDLE;
                            lvl   <= 1'b0;
                        end else begin
                            lvl <= 1'b1;
                            cnt <= eff_h_m1;
                        end
                    end else if (cnt != '0) begin
                        cnt <= cnt_m1;
                    end else begin
                        lvl <= 1'b0;
                        cnt <= cur_h_m1;
                    end
                end
                STOPPING: begin
                    if (cnt != '0) begin
                        cnt <= cnt_m1;
                        if (en) begin
                            state <= RUN;
                        end
                    end else begin
                        lvl <= 1'b0;
                        if (en) begin
                            cnt   <= cur_h_m1;
                            state <= RUN;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    lvl   <= 1'b0;
                end
            endcase
            // A write always lands in the pending slot, even on an apply edge.
            if (cfg_wr) begin
                pend_h <= cfg_half;
                pend_v <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/prog_clock_divider.sv
// Multi-channel runtime-programmable clock divider with config port and phase alignment.
module prog_clock_divider
    import prog_clkdiv_pkg::*;
#(
    parameter int unsigned NUM_CH       = 4,
    parameter int unsigned CNT_W        = CNT_W_DEF,
    parameter int unsigned DEFAULT_HALF = 1,
    localparam int unsigned CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable_all,
    input  logic [NUM_CH-1:0] enable_ch,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_half,
    input  logic              sync_align,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] active
);

    // Per-channel write decode and enable fan-out; out-of-range cfg_ch matches no channel.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic wr;
        logic en;

        assign wr = cfg_we && (cfg_ch == CH_W'(i));
        assign en = enable_all | enable_ch[i];

        clk_div_channel #(
            .CNT_W        (CNT_W),
            .DEFAULT_HALF (DEFAULT_HALF)
        ) u_ch (
            .clock      (clock),
            .reset      (reset),
            .en         (en),
            .sync_align (sync_align),
            .cfg_wr     (wr),
            .cfg_half   (cfg_half),
            .clk_out    (clk_out[i]),
            .active     (active[i])
        );
    end

endmodule

// File: tb/tb_prog_clock_divider.sv
// Scoreboard bench for prog_clock_divider: per-cycle expected output samples are queued by stimulus.
module tb_prog_clock_divider;

    localparam int unsigned NUM_CH = 5;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned CH_W   = 3;

    logic              clock = 1'b0;
    logic              reset;
    logic              enable_all;
    logic [NUM_CH-1:0] enable_ch;
    logic              cfg_we;
    logic [CH_W-1:0]   cfg_ch;
    logic [CNT_W-1:0]  cfg_half;
    logic              sync_align;
    logic [NUM_CH-1:0] clk_out;
    logic [NUM_CH-1:0] active;

    prog_clock_divider #(
        .NUM_CH       (NUM_CH),
        .CNT_W        (CNT_W),
        .DEFAULT_HALF (1)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .enable_all (enable_all),
        .enable_ch  (enable_ch),
        .cfg_we     (cfg_we),
        .cfg_ch     (cfg_ch),
        .cfg_half   (cfg_half),
        .sync_align (sync_align),
        .clk_out    (clk_out),
        .active     (active)
    );

    always #5 clock = ~clock;

    // Count of rising edges so far; samples are tagged with this value.
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int ch;
        int tid;
        bit clk_e;
        bit act_v;
        bit act_e;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    // Monitor: at each falling edge compare every expectation due this cycle.
    always @(negedge clock) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc <= cyc) begin
                total++;
                if (sb[i].cyc < cyc) begin
                    bad++;
                    $display("FAIL t%0d ch%0d sample for cyc %0d missed (now %0d)",
                             sb[i].tid, sb[i].ch, sb[i].cyc, cyc);
                end else begin
                    if (clk_out[sb[i].ch] !== sb[i].clk_e) begin
                        bad++;
                        $display("FAIL t%0d ch%0d cyc %0d clk_out got %b want %b",
                                 sb[i].tid, sb[i].ch, cyc, clk_out[sb[i].ch], sb[i].clk_e);
                    end
                    if (sb[i].act_v) begin
                        total++;
                        if (active[sb[i].ch] !== sb[i].act_e) begin
                            bad++;
                            $display("FAIL t%0d ch%0d cyc %0d active got %b want %b",
                                     sb[i].tid, sb[i].ch, cyc, active[sb[i].ch], sb[i].act_e);
                        end
                    end
                end
                sb.delete(i);
            end
        end
    end

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Queue one expected sample per pattern character, starting at cycle 'first'.
    task automatic expect_seq(input int tid, input int ch, input int first,
                              input string cp, input string ap);
        for (int k = 0; k < cp.len(); k++) begin
            exp_t e;
            e.cyc   = first + k;
            e.ch    = ch;
            e.tid   = tid;
            e.clk_e = (cp.getc(k) == "1");
            e.act_v = (k < ap.len()) && (ap.getc(k) != "-");
            e.act_e = (k < ap.len()) && (ap.getc(k) == "1");
            sb.push_back(e);
        end
    endtask

    // Two reset edges with all inputs idle; every channel must read 0/0 after each.
    task automatic do_reset(input int tid);
        @(negedge clock);
        reset      = 1'b1;
        enable_all = 1'b0;
        enable_ch  = '0;
        cfg_we     = 1'b0;
        cfg_ch     = '0;
        cfg_half   = '0;
        sync_align = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            expect_seq(tid, c, cyc + 1, "00", "00");
        end
        wait_neg(2);
        reset = 1'b0;
    endtask

    initial begin
        int a;
        int t1;
        reset      = 1'b1;
        enable_all = 1'b0;
        enable_ch  = '0;
        cfg_we     = 1'b0;
        cfg_ch     = '0;
        cfg_half   = '0;
        sync_align = 1'b0;

        do_reset(0);

        // T1: ch0 H=3, enable -> rises two edges later, 3 high / 3 low.
        cfg_we = 1'b1; cfg_ch = 3'd0; cfg_half = 8'd3;
        @(negedge clock);
        cfg_we = 1'b0; enable_ch[0] = 1'b1;
        t1 = cyc;
        expect_seq(1, 0, t1 + 1, "0111000111000", "1111111111111");
        wait_neg(14);
        do_reset(10);

        // T2: ch1 H=2, rewrite to H=5 mid high phase -> 2/2 then 5/5.
        cfg_we = 1'b1; cfg_ch = 3'd1; cfg_half = 8'd2;
        @(negedge clock);
        cfg_we = 1'b0; enable_ch[1] = 1'b1;
        t1 = cyc;
        expect_seq(2, 1, t1 + 1, "0110011111000001", "1111111111111111");
        wait_neg(2);
        cfg_we = 1'b1; cfg_half = 8'd5;
        @(negedge clock);
        cfg_we = 1'b0;
        wait_neg(15);
        do_reset(20);

        // T3: ch2 H=4, disable one cycle into high phase -> high phase completes, then stop.
        cfg_we = 1'b1; cfg_ch = 3'd2; cfg_half = 8'd4;
        @(negedge clock);
        cfg_we = 1'b0; enable_ch[2] = 1'b1;
        t1 = cyc;
        expect_seq(3, 2, t1 + 1, "01111000000", "11110000000");
        wait_neg(2);
        enable_ch[2] = 1'b0;
        wait_neg(11);
        do_reset(30);

        // T4: ch0 H=2 and ch1 H=3 out of phase, sync_align realigns both.
        a = cyc;
        expect_seq(4, 0, a + 1, "00110011110011001", "");
        expect_seq(4, 1, a + 1, "00011100111000111", "");
        cfg_we = 1'b1; cfg_ch = 3'd0; cfg_half = 8'd2;
        @(negedge clock);
        cfg_ch = 3'd1; cfg_half = 8'd3; enable_ch[0] = 1'b1;
        @(negedge clock);
        cfg_we = 1'b0; enable_ch[1] = 1'b1;
        wait_neg(5);
        sync_align = 1'b1;
        @(negedge clock);
        sync_align = 1'b0;
        wait_neg(11);
        do_reset(40);

        // T5: H=0 stops ch3 at the boundary; write to cfg_ch=5 must leave ch1 at H=1.
        a = cyc;
        expect_seq(5, 3, a + 1, "0011000000000", "0111100000000");
        expect_seq(5, 1, a + 1, "0010101010101", "0111111111111");
        cfg_we = 1'b1; cfg_ch = 3'd3; cfg_half = 8'd2;
        @(negedge clock);
        cfg_we = 1'b0; enable_ch[1] = 1'b1; enable_ch[3] = 1'b1;
        wait_neg(2);
        cfg_we = 1'b1; cfg_ch = 3'd3; cfg_half = 8'd0;
        @(negedge clock);
        cfg_ch = 3'd5; cfg_half = 8'd7;
        @(negedge clock);
        cfg_we = 1'b0;
        wait_neg(9);
        do_reset(50);

        // T6: all channels at default H=1, reset mid-run drops a pending write.
        a = cyc;
        for (int c = 0; c < NUM_CH; c++) begin
            expect_seq(6, c, a + 1, "010100010101", "111110111111");
        end
        enable_all = 1'b1;
        wait_neg(4);
        cfg_we = 1'b1; cfg_ch = 3'd2; cfg_half = 8'd6;
        @(negedge clock);
        cfg_we = 1'b0; reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        wait_neg(8);
        enable_all = 1'b0;

        // Drain anything still queued, bounded.
        for (int w = 0; (w < 50) && (sb.size() != 0); w++) begin
            @(negedge clock);
        end
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d expectations left, want 0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/prog_clock_divider.md
# prog_clock_divider

Parametrised, runtime-programmable successor to the fixed three-output clock divider: NUM_CH independent divided-clock channels, each with a half-period loaded over a simple config write port. Divisor changes take effect only at period boundaries, and disables only after the output's high phase completes, so no runt pulses occur. A sync pulse phase-aligns all running channels. Sits in the clocking/peripheral area and feeds slow strobes and divided clocks to downstream blocks.

## Interface
Parameters:
- NUM_CH, 4, number of output channels (1..16)
- CNT_W, 8, half-period counter width
- DEFAULT_HALF, 1, half-period loaded into every channel at reset (must be < 2^CNT_W)

Ports:
- clock  in  1  single system clock
- reset  in  1  synchronous, active-high reset
- enable_all  in  1  enables every channel
- enable_ch  in  NUM_CH  per-channel enable; channel i effective enable en_i = enable_all | enable_ch[i]
- cfg_we  in  1  config write strobe, one cycle
- cfg_ch  in  $clog2(NUM_CH) (min 1)  target channel
- cfg_half  in  CNT_W  new half-period H; 0 = stop channel
- sync_align  in  1  single-cycle phase-align request
- clk_out  out  NUM_CH  divided outputs, registered
- active  out  NUM_CH  channel i not IDLE

## Operation
- Per channel: state (IDLE, RUN, STOPPING), down-counter cnt[CNT_W], internal level lvl, current half cur_h, pending half pend_h + pend_v.
- Reset: state IDLE, cnt 0, lvl 0, cur_h DEFAULT_HALF, pend_v 0; clk_out all 0, active all 0.
- Config write: cfg_we with cfg_ch < NUM_CH stores pend_h = cfg_half, pend_v = 1. cfg_ch >= NUM_CH ignored. A second write before application overwrites pend_h.
- Apply point: pending value moves to cur_h (pend_v clears) when the channel is IDLE, or at a period boundary in RUN (the edge where lvl would go 0 -> 1).
- IDLE: if en_i and effective H (pend_h if pend_v else cur_h) != 0 -> RUN, lvl <= 1, cnt <= H-1. Otherwise stay; lvl 0.
- RUN: cnt != 0 -> cnt-1. cnt == 0 -> toggle lvl, reload cnt <= H-1. Output period = 2H cycles, 50% duty. At a period boundary with new H == 0 -> IDLE, lvl stays 0.
- Disable in RUN (en_i low): lvl 0 -> IDLE at once. lvl 1 -> STOPPING.
- STOPPING: keep counting. At cnt == 0 -> lvl 0, IDLE. Re-enable in STOPPING -> back to RUN without disturbing count.
- sync_align: every channel in RUN restarts its period (lvl <= 1, cnt <= H-1, pending applied; H == 0 -> IDLE). A high phase may stretch; a low phase may shorten to a minimum of 1 cycle. IDLE and STOPPING are unaffected.
- Priority at one edge: reset > sync_align > period-boundary logic. A cfg write to a channel at the same edge as its apply point is stored and applied at the next apply point.
- Counter arithmetic is unsigned, CNT_W bits. H max = 2^CNT_W-1. H = 1 gives clock/2.

## Timing
- clk_out[i] = lvl registered one cycle (1-cycle latency). active[i] is combinational from state.
- en_i sampled high at edge k (IDLE, H valid) -> lvl 1 after k -> clk_out rises after k+1.
- clk_out high/low phases are exactly H cycles in steady state.
- Reset asserted mid-operation: all outputs 0 at the first edge after reset is sampled; pending writes are lost.

## Structure
- Shared package prog_clkdiv_pkg: state enum (IDLE, RUN, STOPPING), CNT_W default constant.
- Sub-module clk_div_channel (one channel: counter, state, pending register, output flop), generated NUM_CH times. The top level decodes cfg_ch/cfg_we and fans out enable_all and sync_align.

## Test plan
- Reset, then write ch0 H=3, set enable_ch[0]=1 -> clk_out[0] rises 2 edges later, then 3 high / 3 low repeating. active[0]=1.
- Ch1 running H=2, write H=5 mid high phase -> current period finishes at 2/2, next period is 5/5, with no phase shorter than 2.
- Ch2 H=4, drop enable one cycle into high phase -> 3 more high cycles, clk_out[2] falls, active[2]=0, no further edges.
- Ch0 H=2 and ch1 H=3 running, pulse sync_align -> both clk_out rise on the same edge; the next periods are 2/2 and 3/3.
- Write cfg_half=0 to running ch3 (H=2) -> stops low at the next period boundary. Write with cfg_ch=NUM_CH -> no channel changes.
- Assert reset while all channels run -> all clk_out 0 and all active 0 after one edge. After deassert with enable_all=1 -> all channels restart with H=DEFAULT_HALF.
